apu_register_controller: RTL and testbench
==========================================

// Module: apu_register_controller
// PURPOSE
//  CPU-side register front end of the APU: decodes accesses to $4000-$4017 (5-bit offset),
//  holds channel register banks, drives length-load/clear strobes and channel enables,
//  serves $4015 status reads, and sequences $4017 writes into a delayed frame-sequencer reset.
//  Sits between the CPU bus and the pulse/triangle/noise channels and the frame sequencer.
// PARAMETERS
//  RESET_DELAY  3  clk cycles from $4017 write to seq_reset (+1 when parity flop is odd)
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   asynchronous, active-low (0 = reset)
//  cpu_req        in   1   access request; held high until cpu_ack
//  cpu_we         in   1   1 = write, 0 = read; qualified by cpu_req
//  cpu_addr       in   5   register offset from $4000
//  cpu_wdata      in   8   write data
//  cpu_ack        out  1   one-cycle access-complete pulse
//  cpu_rdata      out  8   read data, valid while cpu_ack=1
//  sq1_reg        out  32  pulse1 {$4003,$4002,$4001,$4000}
//  sq2_reg        out  32  pulse2 {$4007,$4006,$4005,$4004}
//  tri_reg1       out  8   $4008 {control flag, counter reload}
//  tri_reg2       out  8   $400A timer[7:0]
//  tri_reg3       out  8   $400B {length load, timer[10:8]}
//  noise_reg      out  24  {$400F,$400E,$400C}
//  ch_enable      out  4   {noise,tri,sq2,sq1} from $4015
//  len_load       out  4   one-cycle strobe per channel: reload length counter
//  len_clear      out  4   one-cycle strobe per channel: force length counter to 0
//  len_nonzero    in   4   channel length counters > 0
//  frame_irq_set  in   1   frame sequencer IRQ event (one-cycle)
//  frame_mode     out  1   0 = 4-step, 1 = 5-step
//  seq_reset      out  1   one-cycle frame-sequencer reset pulse
//  irq            out  1   frame IRQ to CPU
// BEHAVIOUR
//  Reset: every output and register 0; FSM IDLE; delay counter idle; parity flop 0.
//  FSM IDLE: cpu_req=1 -> perform access, go ACK. ACK: cpu_ack=1 one cycle -> IDLE.
//   One access per 2 cycles; req still high in IDLE after ACK = new access.
//  Write map: 00-03 sq1, 04-07 sq2, 08 tri_reg1, 0A tri_reg2, 0B tri_reg3, 0C/0E/0F noise,
//   15 enables, 17 frame control. 09,0D,10-14,16,18-1F: ignored, still acked.
//  Register outputs update at the ACK edge. Write to 03/07/0B/0F pulses len_load[ch] in ACK
//   cycle only if ch_enable[ch]=1; register byte is written regardless.
//  $4015 write: ch_enable<=wdata[3:0]; each 1->0 transition pulses len_clear[ch] in ACK cycle.
//  Reads: 15 -> {1'b0, frame_irq, 2'b00, len_nonzero}, sampled in IDLE; all else 8'h00.
//   $4015 read clears frame_irq at ACK edge; coincident frame_irq_set wins (flag stays 1).
//  $4017 write: frame_mode<=wdata[7]; inhibit<=wdata[6]; inhibit=1 clears frame_irq same edge.
//   Load countdown = RESET_DELAY + parity; seq_reset pulses when count expires.
//   A new $4017 write during countdown restarts it with new value; no pulse for the old one.
//  Parity flop toggles every clk out of reset. frame_irq set by frame_irq_set when inhibit=0.
//  Mid-operation reset: FSM, pending countdown and strobes abort immediately, no pulses.
// CONFIGURATION
//  APU_FRAME_IRQ_EN defined: frame_irq flag, irq output, status bit 6 as above.
//  Not defined: no flag; irq tied 0; status bit 6 reads 0; inhibit bit stored, no effect.
// STRUCTURE
//  apu_pkg: address offset constants (ADDR_SQ1_0..ADDR_FRAME), channel index constants
//   (CH_SQ1=0..CH_NOISE=3), FSM state encoding.
//  Sub-module frame_reset_timer: countdown + parity flop, in: load/clk/reset, out: seq_reset.
// TESTING
//  Reset low mid-ACK -> cpu_ack, strobes, regs all 0 next cycle; no seq_reset ever issued.
//  Write 15=0x04, then 0B=0x58 -> tri_reg3=0x58, len_load=4'b0100 one cycle with cpu_ack.
//  Write 15=0x00 then 0B=0x58 -> len_clear=4'b0100 on first; no len_load on second.
//  frame_irq_set pulse, read 15 with len_nonzero=4'b1010 -> rdata=0x4A; next read 0x0A.
//  Write 17=0x80 at even parity -> frame_mode=1, seq_reset 3 cycles after ACK; odd -> 4.
//  Write 17=0x40 with irq=1 -> irq=0 at ACK; later frame_irq_set -> irq stays 0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared definitions for the APU CPU-side register front end: register offsets,
// channel indices and the access FSM state encoding.
package apu_pkg;

    localparam logic [4:0] ADDR_SQ1_0   = 5'h00;
    localparam logic [4:0] ADDR_SQ1_1   = 5'h01;
    localparam logic [4:0] ADDR_SQ1_2   = 5'h02;
    localparam logic [4:0] ADDR_SQ1_3   = 5'h03;
    localparam logic [4:0] ADDR_SQ2_0   = 5'h04;
    localparam logic [4:0] ADDR_SQ2_1   = 5'h05;
    localparam logic [4:0] ADDR_SQ2_2   = 5'h06;
    localparam logic [4:0] ADDR_SQ2_3   = 5'h07;
    localparam logic [4:0] ADDR_TRI_LIN = 5'h08;
    localparam logic [4:0] ADDR_TRI_LO  = 5'h0A;
    localparam logic [4:0] ADDR_TRI_HI  = 5'h0B;
    localparam logic [4:0] ADDR_NOI_CTL = 5'h0C;
    localparam logic [4:0] ADDR_NOI_PER = 5'h0E;
    localparam logic [4:0] ADDR_NOI_LEN = 5'h0F;
    localparam logic [4:0] ADDR_STATUS  = 5'h15;
    localparam logic [4:0] ADDR_FRAME   = 5'h17;

    localparam int unsigned CH_SQ1   = 0;
    localparam int unsigned CH_SQ2   = 1;
    localparam int unsigned CH_TRI   = 2;
    localparam int unsigned CH_NOISE = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } apu_state_t;

    function automatic logic [7:0] status_byte(input logic irq_flag, input logic [3:0] nz);
        return {1'b0, irq_flag, 2'b00, nz};
    endfunction

endpackage

// File: rtl/frame_reset_timer.sv
// Delays a $4017 write into a one-cycle frame-sequencer reset pulse; the delay
// grows by one when the free-running parity flop is odd at load time.
module frame_reset_timer #(
    parameter int unsigned RESET_DELAY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic seq_reset
);

    localparam int unsigned CW = $clog2(RESET_DELAY + 2);

    logic          r_parity;
    logic [CW-1:0] r_cnt;
    logic          r_seq_reset;

    // A load always wins over a running countdown, so a superseded write never pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity    <= 1'b0;
            r_cnt       <= '0;
            r_seq_reset <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            if (load) begin
                r_cnt       <= CW'(RESET_DELAY) + CW'(r_parity);
                r_seq_reset <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt       <= r_cnt - CW'(1);
                r_seq_reset <= (r_cnt == CW'(1));
            end else begin
                r_seq_reset <= 1'b0;
            end
        end
    end

    assign seq_reset = r_seq_reset;

endmodule

// File: rtl/apu_register_controller.sv
// CPU register front end of the APU ($4000-$4017): channel register banks, length
// strobes, $4015 status and $4017 frame control. Frame IRQ logic under APU_FRAME_IRQ_EN.
module apu_register_controller
    import apu_pkg::*;
#(
    parameter int unsigned RESET_DELAY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [31:0] sq1_reg,
    output logic [31:0] sq2_reg,
    output logic [7:0]  tri_reg1,
    output logic [7:0]  tri_reg2,
    output logic [7:0]  tri_reg3,
    output logic [23:0] noise_reg,
    output logic [3:0]  ch_enable,
    output logic [3:0]  len_load,
    output logic [3:0]  len_clear,
    input  logic [3:0]  len_nonzero,
    input  logic        frame_irq_set,
    output logic        frame_mode,
    output logic        seq_reset,
    output logic        irq
);

    apu_state_t r_state, w_next_state;
    logic       w_access, w_wr, w_frame_wr, w_status_rd, w_irq_flag;

    logic        r_ack;
    logic [7:0]  r_rdata;
    logic [31:0] r_sq1, r_sq2;
    logic [7:0]  r_tri1, r_tri2, r_tri3;
    logic [23:0] r_noise;
    logic [3:0]  r_ch_enable, r_len_load, r_len_clear;
    logic        r_frame_mode, r_inhibit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: if (cpu_req) begin
                w_access     = 1'b1;
                w_next_state = ST_ACK;
            end
            ST_ACK:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_wr        = w_access & cpu_we;
    assign w_frame_wr  = w_wr & (cpu_addr == ADDR_FRAME);
    assign w_status_rd = w_access & ~cpu_we & (cpu_addr == ADDR_STATUS);

    // Everything an access does lands on the IDLE->ACK edge, so it is visible during ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_sq1        <= '0;
            r_sq2        <= '0;
            r_tri1       <= '0;
            r_tri2       <= '0;
            r_tri3       <= '0;
            r_noise      <= '0;
            r_ch_enable  <= '0;
            r_len_load   <= '0;
            r_len_clear  <= '0;
            r_frame_mode <= 1'b0;
            r_inhibit    <= 1'b0;
        end else begin
            r_ack       <= w_access;
            r_rdata     <= '0;
            r_len_load  <= '0;
            r_len_clear <= '0;
            if (w_status_rd) r_rdata <= status_byte(w_irq_flag, len_nonzero);
            if (w_wr) begin
                case (cpu_addr)
                    ADDR_SQ1_0:   r_sq1[7:0]   <= cpu_wdata;
                    ADDR_SQ1_1:   r_sq1[15:8]  <= cpu_wdata;
                    ADDR_SQ1_2:   r_sq1[23:16] <= cpu_wdata;
                    ADDR_SQ1_3: begin
                        r_sq1[31:24]        <= cpu_wdata;
                        r_len_load[CH_SQ1]  <= r_ch_enable[CH_SQ1];
                    end
                    ADDR_SQ2_0:   r_sq2[7:0]   <= cpu_wdata;
                    ADDR_SQ2_1:   r_sq2[15:8]  <= cpu_wdata;
                    ADDR_SQ2_2:   r_sq2[23:16] <= cpu_wdata;
                    ADDR_SQ2_3: begin
                        r_sq2[31:24]        <= cpu_wdata;
                        r_len_load[CH_SQ2]  <= r_ch_enable[CH_SQ2];
                    end
                    ADDR_TRI_LIN: r_tri1 <= cpu_wdata;
                    ADDR_TRI_LO:  r_tri2 <= cpu_wdata;
                    ADDR_TRI_HI: begin
                        r_tri3              <= cpu_wdata;
                        r_len_load[CH_TRI]  <= r_ch_enable[CH_TRI];
                    end
                    ADDR_NOI_CTL: r_noise[7:0]  <= cpu_wdata;
                    ADDR_NOI_PER: r_noise[15:8] <= cpu_wdata;
                    ADDR_NOI_LEN: begin
                        r_noise[23:16]       <= cpu_wdata;
                        r_len_load[CH_NOISE] <= r_ch_enable[CH_NOISE];
                    end
                    ADDR_STATUS: begin
                        r_ch_enable <= cpu_wdata[3:0];
                        r_len_clear <= r_ch_enable & ~cpu_wdata[3:0];
                    end
                    ADDR_FRAME: begin
                        r_frame_mode <= cpu_wdata[7];
                        r_inhibit    <= cpu_wdata[6];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef APU_FRAME_IRQ_EN
    logic r_frame_irq;
    logic w_inhibit_next;

    // Set beats a status-read clear, but a write that raises inhibit clears it outright.
    assign w_inhibit_next = w_frame_wr ? cpu_wdata[6] : r_inhibit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_frame_irq <= 1'b0;
        else        r_frame_irq <= (frame_irq_set & ~w_inhibit_next)
                                 | (r_frame_irq & ~w_status_rd & ~(w_frame_wr & cpu_wdata[6]));
    end

    assign w_irq_flag = r_frame_irq;
`else
    // Without the flag, inhibit and frame_irq_set are accepted but have no effect.
    assign w_irq_flag = &{1'b0, r_inhibit, frame_irq_set};
`endif

    frame_reset_timer #(
        .RESET_DELAY(RESET_DELAY)
    ) u_frame_reset_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_frame_wr),
        .seq_reset (seq_reset)
    );

    assign cpu_ack    = r_ack;
    assign cpu_rdata  = r_rdata;
    assign sq1_reg    = r_sq1;
    assign sq2_reg    = r_sq2;
    assign tri_reg1   = r_tri1;
    assign tri_reg2   = r_tri2;
    assign tri_reg3   = r_tri3;
    assign noise_reg  = r_noise;
    assign ch_enable  = r_ch_enable;
    assign len_load   = r_len_load;
    assign len_clear  = r_len_clear;
    assign frame_mode = r_frame_mode;
    assign irq        = w_irq_flag;

endmodule

// File: tb/tb_apu_register_controller.sv
// Directed bench for apu_register_controller: table of single accesses plus
// hand sequences for back-to-back access, IRQ, $4017 timing and mid-access reset.
module tb_apu_register_controller;

    localparam int unsigned RD = 3;
`ifdef APU_FRAME_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        clk, reset;
    logic        cpu_req, cpu_we;
    logic [4:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [31:0] sq1_reg, sq2_reg;
    logic [7:0]  tri_reg1, tri_reg2, tri_reg3;
    logic [23:0] noise_reg;
    logic [3:0]  ch_enable, len_load, len_clear, len_nonzero;
    logic        frame_irq_set, frame_mode, seq_reset, irq;

    apu_register_controller #(.RESET_DELAY(RD)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .sq1_reg(sq1_reg), .sq2_reg(sq2_reg),
        .tri_reg1(tri_reg1), .tri_reg2(tri_reg2), .tri_reg3(tri_reg3),
        .noise_reg(noise_reg), .ch_enable(ch_enable), .len_load(len_load),
        .len_clear(len_clear), .len_nonzero(len_nonzero),
        .frame_irq_set(frame_irq_set), .frame_mode(frame_mode),
        .seq_reset(seq_reset), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parity the design should see: toggles on every clock out of reset.
    logic tb_par;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [3:0]  nz;
        logic [7:0]  rdata;
        logic [3:0]  load;
        logic [3:0]  clr;
        logic        chk_reg;
        logic [31:0] reg_v;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [4:0] a, input logic [7:0] d,
                       input logic [3:0] nz, input logic [7:0] rdat, input logic [3:0] ld,
                       input logic [3:0] cl, input logic ck, input logic [31:0] rv);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.nz = nz; v.rdata = rdat;
        v.load = ld; v.clr = cl; v.chk_reg = ck; v.reg_v = rv;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] bank(input logic [4:0] a);
        case (a)
            5'h00, 5'h01, 5'h02, 5'h03: return sq1_reg;
            5'h04, 5'h05, 5'h06, 5'h07: return sq2_reg;
            5'h08: return 32'(tri_reg1);
            5'h0A: return 32'(tri_reg2);
            5'h0B: return 32'(tri_reg3);
            5'h0C, 5'h0E, 5'h0F: return 32'(noise_reg);
            5'h15: return 32'(ch_enable);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic       s_ack, s_ack2, s_irq;
    logic [7:0] s_rdata;
    logic [3:0] s_load, s_clr, s_load2, s_clr2;

    // Entered and left at a negedge with the FSM in IDLE.
    task automatic access(input logic we, input logic [4:0] a, input logic [7:0] d,
                          input logic [3:0] nz);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; len_nonzero = nz;
        @(posedge clk); #1;
        s_ack = cpu_ack; s_rdata = cpu_rdata; s_load = len_load; s_clr = len_clear; s_irq = irq;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; frame_irq_set = 1'b0;
        @(posedge clk); #1;
        s_ack2 = cpu_ack; s_load2 = len_load; s_clr2 = len_clear;
        @(negedge clk);
    endtask

    task automatic frame_write(input string name, input logic [7:0] d);
        int first, cnt;
        int unsigned exp_d;
        first = -1; cnt = 0;
        exp_d = RD + 32'(tb_par);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h17; cpu_wdata = d;
        @(posedge clk); #1;
        chk({name, "_ack"}, 32'(cpu_ack), 32'd1);
        s_irq = irq;
        if (seq_reset) begin first = 0; cnt++; end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (seq_reset) begin
                if (first < 0) first = c;
                cnt++;
            end
        end
        @(negedge clk);
        chk({name, "_seq_delay"}, 32'(first), 32'(exp_d));
        chk({name, "_seq_count"}, 32'(cnt), 32'd1);
    endtask

    task automatic pulse_irq_set();
        frame_irq_set = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_irq_set = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] acks;
        int         first, cnt;
        logic       p2;

        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        len_nonzero = '0; frame_irq_set = 1'b0;

        // Vector table: {we, addr, wdata, len_nonzero, rdata, len_load, len_clear, check reg, reg}
        add(1, 5'h00, 8'h11, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_0011);
        add(1, 5'h01, 8'h22, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_2211);
        add(1, 5'h02, 8'h33, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0033_2211);
        add(1, 5'h03, 8'h44, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h4433_2211);
        add(1, 5'h15, 8'h04, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_0004);
        add(1, 5'h0B, 8'h58, 4'h0, 8'h00, 4'b0100, 4'b0000, 1, 32'h0000_0058);
        add(1, 5'h15, 8'h0F, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_000F);
        add(1, 5'h07, 8'hA5, 4'h0, 8'h00, 4'b0010, 4'b0000, 1, 32'hA500_0000);
        add(1, 5'h03, 8'h08, 4'h0, 8'h00, 4'b0001, 4'b0000, 1, 32'h0833_2211);
        add(1, 5'h0F, 8'h30, 4'h0, 8'h00, 4'b1000, 4'b0000, 1, 32'h0030_0000);
        add(1, 5'h0C, 8'h1F, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0030_001F);
        add(1, 5'h0E, 8'h8D, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0030_8D1F);
        add(1, 5'h08, 8'h81, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_0081);
        add(1, 5'h0A, 8'hEE, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_00EE);
        add(1, 5'h09, 8'hFF, 4'h0, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(1, 5'h0D, 8'hFF, 4'h0, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(1, 5'h10, 8'hFF, 4'h0, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(1, 5'h14, 8'hFF, 4'h0, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(1, 5'h16, 8'hFF, 4'h0, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(1, 5'h1F, 8'hFF, 4'h0, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(1, 5'h15, 8'h05, 4'h0, 8'h00, 4'b0000, 4'b1010, 1, 32'h0000_0005);
        add(1, 5'h15, 8'h00, 4'h0, 8'h00, 4'b0000, 4'b0101, 1, 32'h0000_0000);
        add(1, 5'h0B, 8'h58, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'h0000_0058);
        add(1, 5'h04, 8'h01, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'hA500_0001);
        add(1, 5'h05, 8'h02, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'hA500_0201);
        add(1, 5'h06, 8'h03, 4'h0, 8'h00, 4'b0000, 4'b0000, 1, 32'hA503_0201);
        add(0, 5'h15, 8'h00, 4'hA, 8'h0A, 4'b0000, 4'b0000, 0, 32'h0);
        add(0, 5'h00, 8'h00, 4'hF, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);
        add(0, 5'h15, 8'h00, 4'h5, 8'h05, 4'b0000, 4'b0000, 0, 32'h0);
        add(0, 5'h17, 8'h00, 4'hF, 8'h00, 4'b0000, 4'b0000, 0, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_rdata", {23'd0, cpu_ack, cpu_rdata}, 32'd0);
        chk("rst_sq1", sq1_reg, 32'd0);
        chk("rst_sq2", sq2_reg, 32'd0);
        chk("rst_tri_noise", {tri_reg1, tri_reg2, tri_reg3, 8'd0} | 32'(noise_reg), 32'd0);
        chk("rst_strobes", {20'd0, ch_enable, len_load, len_clear}, 32'd0);
        chk("rst_misc", {29'd0, frame_mode, seq_reset, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].nz);
            chk($sformatf("v%0d_ack", i), 32'(s_ack), 32'd1);
            chk($sformatf("v%0d_rdata", i), 32'(s_rdata), 32'(vecs[i].rdata));
            chk($sformatf("v%0d_len_load", i), 32'(s_load), 32'(vecs[i].load));
            chk($sformatf("v%0d_len_clear", i), 32'(s_clr), 32'(vecs[i].clr));
            chk($sformatf("v%0d_one_cycle", i), {23'd0, s_ack2, s_load2, s_clr2}, 32'd0);
            if (vecs[i].chk_reg)
                chk($sformatf("v%0d_reg", i), bank(vecs[i].addr), vecs[i].reg_v);
        end

        chk("final_sq1", sq1_reg, 32'h0833_2211);
        chk("final_sq2", sq2_reg, 32'hA503_0201);
        chk("final_tri", {8'd0, tri_reg1, tri_reg2, tri_reg3}, 32'h0081_EE58);
        chk("final_noise", 32'(noise_reg), 32'h0030_8D1F);
        chk("final_misc", {24'd0, ch_enable, 1'b0, frame_mode, seq_reset, irq}, 32'd0);

        // Request held high: a new access starts every other cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h0A; cpu_wdata = 8'h11;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            acks[c] = cpu_ack;
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        chk("b2b_ack_pattern", 32'(acks), 32'b0101);
        chk("b2b_tri_reg2", 32'(tri_reg2), 32'h11);

        // Frame IRQ set, then status read clears it
        pulse_irq_set();
        chk("irq_after_set", 32'(irq), 32'(IRQ_EN));
        access(1'b0, 5'h15, 8'h00, 4'b1010);
        chk("status_with_irq", 32'(s_rdata), 32'(status_byte_exp(IRQ_EN, 4'b1010)));
        chk("irq_cleared_by_read", 32'(irq), 32'd0);
        access(1'b0, 5'h15, 8'h00, 4'b1010);
        chk("status_after_clear", 32'(s_rdata), 32'h0A);

        // Set coincident with status read: set wins
        frame_irq_set = 1'b1;
        access(1'b0, 5'h15, 8'h00, 4'b0011);
        chk("coinc_rdata", 32'(s_rdata), 32'h03);
        chk("coinc_irq_kept", 32'(irq), 32'(IRQ_EN));
        access(1'b0, 5'h15, 8'h00, 4'b0011);
        chk("coinc_second_read", 32'(s_rdata), 32'(status_byte_exp(IRQ_EN, 4'b0011)));

        // $4017 timing at both parities
        for (int want = 0; want < 2; want++) begin
            for (int g = 0; g < 3 && tb_par != want[0]; g++) begin
                @(posedge clk); @(negedge clk);
            end
            chk($sformatf("par%0d_align", want), 32'(tb_par), 32'(want));
            frame_write($sformatf("f17_par%0d", want), 8'h80);
            chk($sformatf("par%0d_frame_mode", want), 32'(frame_mode), 32'd1);
        end

        // Second $4017 write during countdown restarts it; only one pulse
        first = -1; cnt = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h17; cpu_wdata = 8'h00;
        @(posedge clk); #1;
        if (seq_reset) cnt++;
        @(negedge clk);
        @(posedge clk); #1;
        if (seq_reset) cnt++;
        @(negedge clk);
        cpu_wdata = 8'h80;
        p2 = tb_par;
        for (int c = 2; c <= 12; c++) begin
            @(posedge clk); #1;
            if (seq_reset) begin
                if (first < 0) first = c;
                cnt++;
            end
            if (c == 2) begin
                @(negedge clk);
                cpu_req = 1'b0; cpu_we = 1'b0;
            end
        end
        @(negedge clk);
        chk("restart_delay", 32'(first), 32'(2 + RD + 32'(p2)));
        chk("restart_count", 32'(cnt), 32'd1);
        chk("restart_frame_mode", 32'(frame_mode), 32'd1);

        // Inhibit clears IRQ at ACK and blocks later sets
        pulse_irq_set();
        chk("inh_irq_before", 32'(irq), 32'(IRQ_EN));
        frame_write("f17_inhibit", 8'h40);
        chk("inh_irq_at_ack", 32'(s_irq), 32'd0);
        chk("inh_frame_mode", 32'(frame_mode), 32'd0);
        pulse_irq_set();
        chk("inh_irq_blocked", 32'(irq), 32'd0);

        // Reset in the middle of an ACK cycle aborts everything
        access(1'b1, 5'h15, 8'h01, 4'h0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h17; cpu_wdata = 8'h00;
        @(posedge clk); #1;
        @(negedge clk);
        cpu_addr = 5'h03; cpu_wdata = 8'h77;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("mid_ack_ack", 32'(cpu_ack), 32'd1);
        chk("mid_ack_load", 32'(len_load), 32'b0001);
        chk("mid_ack_sq1", sq1_reg, 32'h7733_2211);
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        chk("rst2_ack_strobes", {23'd0, cpu_ack, len_load, len_clear}, 32'd0);
        chk("rst2_regs", sq1_reg | sq2_reg | 32'(noise_reg) | {8'd0, tri_reg1, tri_reg2, tri_reg3}, 32'd0);
        chk("rst2_misc", {28'd0, ch_enable} | {29'd0, frame_mode, seq_reset, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (seq_reset) cnt++;
        end
        chk("rst2_no_seq_reset", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic [7:0] status_byte_exp(input logic f, input logic [3:0] nz);
        return {1'b0, f, 2'b00, nz};
    endfunction

endmodule
